// File: rtl/tap_sequencer_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : tap_sequencer_mux_if
// Description : Bus bundle for tap_sequencer_mux. Groups the datapath
//               controls (en/start/x_in) and the framed sample output.
//               master = datapath side driving the sequencer,
//               slave  = the sequencer itself.
// Ports       : en, start, x_in (master -> slave)
//               busy, sel_onehot, x_out, out_valid, out_first, out_last,
//               overflow (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface tap_sequencer_mux_if #(
    parameter int N   = 3,
    parameter int WII = 2,
    parameter int WFI = 6,
    parameter int WIO = 2,
    parameter int WFO = 6
);
    logic                     en;
    logic                     start;
    logic [N*(WII+WFI)-1:0]   x_in;
    logic                     busy;
    logic [N-1:0]             sel_onehot;
    logic [WIO+WFO-1:0]       x_out;
    logic                     out_valid;
    logic                     out_first;
    logic                     out_last;
    logic                     overflow;

    modport master (
        output en, start, x_in,
        input  busy, sel_onehot, x_out, out_valid, out_first, out_last, overflow
    );

    modport slave (
        input  en, start, x_in,
        output busy, sel_onehot, x_out, out_valid, out_first, out_last, overflow
    );
endinterface
`default_nettype wire

// File: rtl/tap_sequencer_mux.sv
`default_nettype none
// ============================================================================
// Module      : tap_sequencer_mux
// Description : Sequenced one-hot tap selector. On start, snapshots N input
//               samples and walks a one-hot select across them, one tap per
//               enabled cycle, emitting each sample converted from WII.WFI to
//               WIO.WFO fixed point with valid/first/last framing.
// Ports       : clk, rst (sync, active-high)
//               bus : tap_sequencer_mux_if.slave (en, start, x_in in;
//                     busy, sel_onehot, x_out, out_valid, out_first,
//                     out_last, overflow out)
// Config      : MUX_SAT_EN defined   -> saturate x_out on integer overflow
//               MUX_SAT_EN undefined -> wrap (keep low bits); overflow still
//                                       reported
// Revision    : 1.0 - initial release
// ============================================================================
module tap_sequencer_mux #(
    parameter int N   = 3,
    parameter int WII = 2,
    parameter int WFI = 6,
    parameter int WIO = 2,
    parameter int WFO = 6
) (
    input  logic               clk,
    input  logic               rst,
    tap_sequencer_mux_if.slave bus
);
    localparam int WI = WII + WFI;
    localparam int WO = WIO + WFO;
    localparam int WA = WII + WFO;                          // after binary-point alignment
    localparam int WE = ((WII > WIO) ? WII : WIO) + WFO;    // wide enough for either integer part

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sel_q, sel_d;
    logic [N*WI-1:0] snap_q, snap_d;
    logic [WO-1:0]   x_out_q, x_out_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;

    logic [WI-1:0]   w_tap;
    logic [WA-1:0]   w_aligned;
    logic [WE-1:0]   w_ext;
    logic [WE-WO:0]  w_top;
    logic            w_ovf;
    logic [WO-1:0]   w_conv;
    logic            w_illegal;

    // One-hot select of the snapshot; a zero select yields zero.
    always_comb begin
        w_tap = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q[i]) begin
                w_tap = w_tap | snap_q[i*WI +: WI];
            end
        end
    end

    // Fraction alignment: widen by zero-filling LSBs, narrow by dropping
    // LSBs (arithmetic shift = truncate toward -inf).
    generate
        if (WFO > WFI) begin : g_frac_widen
            assign w_aligned = {w_tap, {(WFO-WFI){1'b0}}};
        end else if (WFO < WFI) begin : g_frac_narrow
            assign w_aligned = WA'($signed(w_tap) >>> (WFI - WFO));
        end else begin : g_frac_same
            assign w_aligned = w_tap;
        end
    endgenerate

    assign w_ext = WE'($signed(w_aligned));

    // Bits above the new sign bit, plus the new sign bit itself, must all
    // agree; otherwise the value does not fit in WIO integer bits.
    assign w_top = w_ext[WE-1:WO-1];
    assign w_ovf = ~((&w_top) | ~(|w_top));

`ifdef MUX_SAT_EN
    assign w_conv = w_ovf ? (w_ext[WE-1] ? {1'b1, {(WO-1){1'b0}}}
                                         : {1'b0, {(WO-1){1'b1}}})
                          : w_ext[WO-1:0];
`else
    assign w_conv = w_ext[WO-1:0];
`endif

    // Select must be zero in IDLE and exactly one-hot in RUN.
    assign w_illegal = ((sel_q & (sel_q - N'(1))) != '0) ||
                       ((state_q == ST_RUN) != (sel_q != '0));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        x_out_d = x_out_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        ovf_d   = 1'b0;

        if (w_illegal) begin
            state_d = ST_IDLE;
            sel_d   = '0;
        end else if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        snap_d  = bus.x_in;
                        sel_d   = N'(1);
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_out_d = w_conv;
                    ovf_d   = w_ovf;
                    valid_d = 1'b1;
                    first_d = sel_q[0];
                    last_d  = sel_q[N-1];
                    if (sel_q[N-1]) begin
                        // Start on the final tap chains the next frame gaplessly.
                        if (bus.start) begin
                            snap_d = bus.x_in;
                            sel_d  = N'(1);
                        end else begin
                            state_d = ST_IDLE;
                            sel_d   = '0;
                        end
                    end else begin
                        sel_d = {sel_q[N-2:0], 1'b0};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            snap_q  <= '0;
            x_out_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            x_out_q <= x_out_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.sel_onehot = sel_q;
    assign bus.x_out      = x_out_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_first  = first_q;
    assign bus.out_last   = last_q;
    assign bus.overflow   = ovf_q;
endmodule
`default_nettype wire
